// File: rtl/xm23_dev_ctrl.sv
// XM-23 device register block: NUM_DEV CSR/data channels with DBA/OF status and device handshakes.
// Optional prioritised interrupt logic is enabled by defining XM23_DEV_IRQ_EN.
module xm23_dev_ctrl #(
   parameter int                 NUM_DEV  = 5,
   parameter logic [15:0]        DEV_BASE = 16'h0000,
   parameter logic [NUM_DEV-1:0] OUT_MASK = 5'b10000
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   input  logic                 bus_req,
   input  logic                 bus_we,
   input  logic                 bus_byte,
   input  logic [15:0]          bus_addr,
   input  logic [15:0]          bus_wdata,
   output logic [15:0]          bus_rdata,
   output logic                 bus_ack,
   output logic                 bus_err,
   input  logic [NUM_DEV-1:0]   dev_in_valid,
   input  logic [8*NUM_DEV-1:0] dev_in_data,
   output logic [NUM_DEV-1:0]   dev_out_valid,
   output logic [8*NUM_DEV-1:0] dev_out_data,
   input  logic [NUM_DEV-1:0]   dev_out_ready,
   output logic                 irq_req,
   output logic [3:0]           irq_vect,
   output logic [2:0]           irq_pri,
   input  logic                 irq_ack
);

   logic [16:0] diff;
   logic [15:0] offset;
   logic        in_win, acc, misal, rd_ok, wr_ok, hit_csr, hit_data;
   logic [3:0]  sel;
   logic [7:0]  wr_byte;
   logic [7:0]  csr_val  [NUM_DEV];
   logic [7:0]  data_val [NUM_DEV];

   // 17-bit subtraction gives the below-base test without a constant compare
   assign diff     = {1'b0, bus_addr} - {1'b0, DEV_BASE};
   assign offset   = diff[15:0];
   assign in_win   = !diff[16] && (offset < 16'(2 * NUM_DEV));
   assign acc      = bus_req && in_win;
   assign misal    = !bus_byte && offset[0];
   assign rd_ok    = acc && !misal && !bus_we;
   assign wr_ok    = acc && !misal && bus_we;
   assign sel      = offset[4:1];
   assign hit_csr  = !offset[0];
   assign hit_data = offset[0] || !bus_byte;
   assign wr_byte  = bus_byte ? bus_wdata[7:0] : bus_wdata[15:8];

`ifdef XM23_DEV_IRQ_EN
   logic [2:0]         pri_val [NUM_DEV];
   logic [NUM_DEV-1:0] lvl;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DEV; gi++) begin : g_ch
         localparam logic IS_OUT = OUT_MASK[gi];
         logic       ch_sel, rd_csr, rd_data, wr_csr, wr_data, push, hs;
         logic       ie_q, ie_d, dba_q, dba_d, of_q, of_d, vld_q, vld_d;
         logic [2:0] pri_q, pri_d;
         logic [7:0] data_q, data_d;

         assign ch_sel  = (sel == 4'(gi));
         assign rd_csr  = rd_ok && ch_sel && hit_csr;
         assign rd_data = rd_ok && ch_sel && hit_data;
         assign wr_csr  = wr_ok && ch_sel && hit_csr;
         assign wr_data = wr_ok && ch_sel && hit_data;
         assign push    = !IS_OUT && dev_in_valid[gi];
         assign hs      = IS_OUT && vld_q && dev_out_ready[gi];

         always_comb begin
            ie_d   = ie_q;
            pri_d  = pri_q;
            dba_d  = dba_q;
            of_d   = of_q;
            vld_d  = vld_q;
            data_d = data_q;
            if (rd_csr) of_d = 1'b0;
            if (wr_csr) begin
               ie_d  = bus_wdata[0];
               pri_d = bus_wdata[7:5];
            end
            if (IS_OUT) begin
               // a write racing the handshake refills the slot instead of overflowing it
               if (wr_data) begin
                  data_d = wr_byte;
                  vld_d  = 1'b1;
                  dba_d  = 1'b0;
                  if (!dba_q && !hs) of_d = 1'b1;
               end else if (hs) begin
                  vld_d = 1'b0;
                  dba_d = 1'b1;
               end
            end else begin
               if (push) begin
                  data_d = dev_in_data[8*gi +: 8];
                  dba_d  = 1'b1;
                  if (dba_q && !rd_data) of_d = 1'b1;
               end else if (rd_data) begin
                  dba_d = 1'b0;
               end
            end
         end

         always_ff @(posedge Clock) begin
            if (!Reset_n) begin
               ie_q   <= 1'b0;
               pri_q  <= 3'd0;
               dba_q  <= IS_OUT;
               of_q   <= 1'b0;
               vld_q  <= 1'b0;
               data_q <= 8'h00;
            end else begin
               ie_q   <= ie_d;
               pri_q  <= pri_d;
               dba_q  <= dba_d;
               of_q   <= of_d;
               vld_q  <= vld_d;
               data_q <= data_d;
            end
         end

         assign csr_val[gi]              = {pri_q, 1'b0, of_q, dba_q, IS_OUT, ie_q};
         assign data_val[gi]             = data_q;
         assign dev_out_valid[gi]        = vld_q;
         assign dev_out_data[8*gi +: 8]  = data_q;
`ifdef XM23_DEV_IRQ_EN
         assign pri_val[gi] = pri_q;
         assign lvl[gi]     = ie_q & dba_q;
`endif
      end
   endgenerate

   logic [15:0] rdata_d, rdata_q;
   logic        ack_d, ack_q, err_d, err_q;

   always_comb begin
      ack_d   = acc;
      err_d   = acc && misal;
      rdata_d = 16'h0000;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (rd_ok && sel == 4'(i)) begin
            if (!bus_byte)      rdata_d = {data_val[i], csr_val[i]};
            else if (offset[0]) rdata_d = {8'h00, data_val[i]};
            else                rdata_d = {8'h00, csr_val[i]};
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus_ack   = ack_q;
   assign bus_err   = err_q;
   assign bus_rdata = rdata_q;

`ifdef XM23_DEV_IRQ_EN
   logic [NUM_DEV-1:0] pend_q, pend_d, arm_q, arm_d;
   logic               irq_req_q, irq_req_d;
   logic [3:0]         vect_q, vect_d;
   logic [2:0]         ipri_q, ipri_d;

   always_comb begin
      pend_d    = pend_q;
      arm_d     = arm_q;
      irq_req_d = 1'b0;
      vect_d    = 4'd0;
      ipri_d    = 3'd0;
      // an acked channel stays disarmed until IE&DBA drops again
      for (int i = 0; i < NUM_DEV; i++) begin
         if (!lvl[i]) arm_d[i] = 1'b1;
         if (irq_ack && irq_req_q && vect_q == 4'(i)) begin
            pend_d[i] = 1'b0;
            arm_d[i]  = 1'b0;
         end else if (lvl[i] && arm_q[i] && !pend_q[i]) begin
            pend_d[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_DEV; i++) begin
         if (pend_d[i] && (!irq_req_d || pri_val[i] > ipri_d)) begin
            irq_req_d = 1'b1;
            vect_d    = 4'(i);
            ipri_d    = pri_val[i];
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         pend_q    <= '0;
         arm_q     <= '1;
         irq_req_q <= 1'b0;
         vect_q    <= 4'd0;
         ipri_q    <= 3'd0;
      end else begin
         pend_q    <= pend_d;
         arm_q     <= arm_d;
         irq_req_q <= irq_req_d;
         vect_q    <= vect_d;
         ipri_q    <= ipri_d;
      end
   end

   assign irq_req  = irq_req_q;
   assign irq_vect = vect_q;
   assign irq_pri  = ipri_q;
`else
   logic unused_irq_ack;
   assign unused_irq_ack = irq_ack;
   assign irq_req        = 1'b0;
   assign irq_vect       = 4'd0;
   assign irq_pri        = 3'd0;
`endif

endmodule

// File: tb/tb_xm23_dev_ctrl.sv
// Bench for xm23_dev_ctrl: directed vector table, randomized cycles against a
// channel-level reference model, and an interrupt sequence when XM23_DEV_IRQ_EN is set.
module tb_xm23_dev_ctrl;
   localparam int           N     = 5;
   localparam logic [15:0]  BASE  = 16'h0000;
   localparam logic [N-1:0] OMASK = 5'b10000;

   logic           Clock = 1'b0;
   logic           Reset_n = 1'b0;
   logic           bus_req = 1'b0, bus_we = 1'b0, bus_byte = 1'b0;
   logic [15:0]    bus_addr = 16'h0000, bus_wdata = 16'h0000;
   logic [15:0]    bus_rdata;
   logic           bus_ack, bus_err;
   logic [N-1:0]   dev_in_valid = '0;
   logic [8*N-1:0] dev_in_data = '0;
   logic [N-1:0]   dev_out_valid;
   logic [8*N-1:0] dev_out_data;
   logic [N-1:0]   dev_out_ready = '0;
   logic           irq_req;
   logic [3:0]     irq_vect;
   logic [2:0]     irq_pri;
   logic           irq_ack = 1'b0;

   xm23_dev_ctrl #(.NUM_DEV(N), .DEV_BASE(BASE), .OUT_MASK(OMASK)) dut (
      .Clock(Clock), .Reset_n(Reset_n),
      .bus_req(bus_req), .bus_we(bus_we), .bus_byte(bus_byte),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack), .bus_err(bus_err),
      .dev_in_valid(dev_in_valid), .dev_in_data(dev_in_data),
      .dev_out_valid(dev_out_valid), .dev_out_data(dev_out_data),
      .dev_out_ready(dev_out_ready),
      .irq_req(irq_req), .irq_vect(irq_vect), .irq_pri(irq_pri), .irq_ack(irq_ack)
   );

   always #5 Clock = ~Clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // channel-level reference state
   bit       m_ie  [N];
   bit [2:0] m_pri [N];
   bit       m_dba [N];
   bit       m_of  [N];
   bit       m_vld [N];
   bit [7:0] m_data[N];
   logic        e_ack, e_err;
   logic [15:0] e_rd;

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         m_ie[c] = 0; m_pri[c] = 0; m_of[c] = 0; m_vld[c] = 0; m_data[c] = 0;
         m_dba[c] = OMASK[c];
      end
   endtask

   function automatic logic [7:0] csr_of(input int c);
      return {m_pri[c], 1'b0, m_of[c], m_dba[c], OMASK[c], m_ie[c]};
   endfunction

   task automatic model_cycle(input bit req, input bit we, input bit byt,
                              input logic [15:0] addr, input logic [15:0] wd,
                              input logic [N-1:0] inv, input logic [8*N-1:0] ind,
                              input logic [N-1:0] rdy);
      int off, ch;
      bit inwin, isdata, rd, wr;
      off    = int'(addr) - int'(BASE);
      inwin  = req && off >= 0 && off < 2*N;
      isdata = inwin && (off % 2 == 1);
      ch     = inwin ? off / 2 : -1;
      e_ack  = inwin;
      e_err  = inwin && !byt && isdata;
      e_rd   = 16'h0000;
      rd     = inwin && !e_err && !we;
      wr     = inwin && !e_err && we;
      if (rd) e_rd = byt ? (isdata ? {8'h00, m_data[ch]} : {8'h00, csr_of(ch)})
                         : {m_data[ch], csr_of(ch)};
      for (int c = 0; c < N; c++) begin
         bit here, rcsr, rdat, wcsr, wdat, ovf, hs;
         here = (c == ch);
         rcsr = rd && here && (!byt || !isdata);
         rdat = rd && here && (!byt || isdata);
         wcsr = wr && here && (!byt || !isdata);
         wdat = wr && here && (!byt || isdata);
         ovf  = 0;
         if (OMASK[c]) begin
            hs = m_vld[c] && rdy[c];
            if (wdat) begin
               if (!hs && !m_dba[c]) ovf = 1;
               m_data[c] = byt ? wd[7:0] : wd[15:8];
               m_vld[c] = 1;
               m_dba[c] = 0;
            end else if (hs) begin
               m_vld[c] = 0;
               m_dba[c] = 1;
            end
         end else if (inv[c]) begin
            if (m_dba[c] && !rdat) ovf = 1;
            m_data[c] = ind[8*c +: 8];
            m_dba[c] = 1;
         end else if (rdat) begin
            m_dba[c] = 0;
         end
         if (rcsr) m_of[c] = 0;
         if (ovf)  m_of[c] = 1;
         if (wcsr) begin
            m_ie[c]  = wd[0];
            m_pri[c] = wd[7:5];
         end
      end
   endtask

   task automatic step(input string tag, input bit req, input bit we, input bit byt,
                       input logic [15:0] addr, input logic [15:0] wd,
                       input logic [N-1:0] inv, input logic [8*N-1:0] ind,
                       input logic [N-1:0] rdy, input bit ack_in);
      logic [N-1:0] ev;
      @(negedge Clock);
      bus_req = req; bus_we = we; bus_byte = byt; bus_addr = addr; bus_wdata = wd;
      dev_in_valid = inv; dev_in_data = ind; dev_out_ready = rdy; irq_ack = ack_in;
      model_cycle(req, we, byt, addr, wd, inv, ind, rdy);
      @(posedge Clock);
      #1;
      chk({tag, " ack"}, 32'(bus_ack), 32'(e_ack));
      chk({tag, " err"}, 32'(bus_err), 32'(e_err));
      if (e_ack) chk({tag, " rdata"}, 32'(bus_rdata), 32'(e_rd));
      for (int c = 0; c < N; c++) ev[c] = m_vld[c];
      chk({tag, " out_valid"}, 32'(dev_out_valid), 32'(ev));
      for (int c = 0; c < N; c++)
         if (OMASK[c]) chk({tag, " out_data"}, 32'(dev_out_data[8*c +: 8]), 32'(m_data[c]));
`ifndef XM23_DEV_IRQ_EN
      chk({tag, " irq_tied"}, {24'd0, irq_req, irq_vect, irq_pri}, 32'd0);
`endif
      $display("%s req=%0d we=%0d byte=%0d addr=%h wd=%h push=%b rdy=%b -> ack=%0d err=%0d rdata=%h vld=%b",
               tag, req, we, byt, addr, wd, inv, rdy, bus_ack, bus_err, bus_rdata, dev_out_valid);
      bus_req = 0; dev_in_valid = '0; dev_out_ready = '0; irq_ack = 0;
   endtask

   // reset is held while a bus write and device pushes are active; none may survive
   task automatic do_reset();
      @(negedge Clock);
      Reset_n = 0; bus_req = 1; bus_we = 1; bus_byte = 1; bus_addr = 16'h0009;
      bus_wdata = 16'hFFFF; dev_in_valid = '1; dev_in_data = '1; dev_out_ready = '1;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      Reset_n = 1; bus_req = 0; dev_in_valid = '0; dev_out_ready = '0;
      model_reset();
      chk("reset ack", 32'(bus_ack), 32'd0);
      chk("reset err", 32'(bus_err), 32'd0);
      chk("reset rdata", 32'(bus_rdata), 32'd0);
      chk("reset out_valid", 32'(dev_out_valid), 32'd0);
      chk("reset irq", {24'd0, irq_req, irq_vect, irq_pri}, 32'd0);
      $display("reset released");
   endtask

   typedef struct {
      bit          req, we, byt;
      logic [15:0] addr, wd;
      int          pch;
      logic [7:0]  pb;
      bit          rdy;
      bit          e_ack, e_err;
      logic [15:0] e_rd;
      bit          e_vld;
      logic [7:0]  e_od;
   } vec_t;

   vec_t tbl[30];

   initial begin
      logic [N-1:0]   inv, rdy;
      logic [8*N-1:0] ind;
      logic [15:0]    addr;
      int             r;

      //             req we byt addr     wd       pch pb     rdy ack err rdata    vld od
      tbl[0]  = '{1, 0, 0, 16'h0008, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h0006, 0, 8'h00};
      tbl[1]  = '{0, 0, 0, 16'h0000, 16'h0000,  1, 8'hA5, 0, 0, 0, 16'h0000, 0, 8'h00};
      tbl[2]  = '{1, 0, 1, 16'h0003, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h00A5, 0, 8'h00};
      tbl[3]  = '{1, 0, 1, 16'h0002, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h0000, 0, 8'h00};
      tbl[4]  = '{0, 0, 0, 16'h0000, 16'h0000,  1, 8'h11, 0, 0, 0, 16'h0000, 0, 8'h00};
      tbl[5]  = '{0, 0, 0, 16'h0000, 16'h0000,  1, 8'h22, 0, 0, 0, 16'h0000, 0, 8'h00};
      tbl[6]  = '{1, 0, 1, 16'h0002, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h000C, 0, 8'h00};
      tbl[7]  = '{1, 0, 1, 16'h0002, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h0004, 0, 8'h00};
      tbl[8]  = '{1, 0, 1, 16'h0003, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h0022, 0, 8'h00};
      tbl[9]  = '{1, 1, 1, 16'h0009, 16'h005A, -1, 8'h00, 0, 1, 0, 16'h0000, 1, 8'h5A};
      tbl[10] = '{1, 0, 1, 16'h0008, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h0002, 1, 8'h5A};
      tbl[11] = '{1, 1, 1, 16'h0009, 16'h003C, -1, 8'h00, 0, 1, 0, 16'h0000, 1, 8'h3C};
      tbl[12] = '{1, 0, 1, 16'h0008, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h000A, 1, 8'h3C};
      tbl[13] = '{0, 0, 0, 16'h0000, 16'h0000, -1, 8'h00, 1, 0, 0, 16'h0000, 0, 8'h3C};
      tbl[14] = '{1, 0, 1, 16'h0008, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h0006, 0, 8'h3C};
      tbl[15] = '{0, 0, 0, 16'h0000, 16'h0000,  2, 8'h77, 0, 0, 0, 16'h0000, 0, 8'h3C};
      tbl[16] = '{1, 0, 0, 16'h0005, 16'h0000, -1, 8'h00, 0, 1, 1, 16'h0000, 0, 8'h3C};
      tbl[17] = '{1, 0, 1, 16'h0004, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h0004, 0, 8'h3C};
      tbl[18] = '{1, 0, 1, 16'h0040, 16'h0000, -1, 8'h00, 0, 0, 0, 16'h0000, 0, 8'h3C};
      tbl[19] = '{1, 1, 0, 16'h0008, 16'h9921, -1, 8'h00, 0, 1, 0, 16'h0000, 1, 8'h99};
      tbl[20] = '{1, 0, 0, 16'h0008, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h9923, 1, 8'h99};
      tbl[21] = '{1, 1, 1, 16'h0009, 16'h0044, -1, 8'h00, 1, 1, 0, 16'h0000, 1, 8'h44};
      tbl[22] = '{1, 0, 1, 16'h0008, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h0023, 1, 8'h44};
      tbl[23] = '{0, 0, 0, 16'h0000, 16'h0000,  3, 8'hAA, 0, 0, 0, 16'h0000, 1, 8'h44};
      tbl[24] = '{1, 0, 1, 16'h0007, 16'h0000,  3, 8'hBB, 0, 1, 0, 16'h00AA, 1, 8'h44};
      tbl[25] = '{1, 0, 1, 16'h0006, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h0004, 1, 8'h44};
      tbl[26] = '{1, 0, 1, 16'h0007, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h00BB, 1, 8'h44};
      tbl[27] = '{1, 1, 1, 16'h0006, 16'h00FF,  3, 8'hCC, 0, 1, 0, 16'h0000, 1, 8'h44};
      tbl[28] = '{1, 0, 1, 16'h0006, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h00E5, 1, 8'h44};
      tbl[29] = '{1, 0, 1, 16'h0007, 16'h0000, -1, 8'h00, 0, 1, 0, 16'h00CC, 1, 8'h44};

      do_reset();

      for (int i = 0; i < 30; i++) begin
         inv = '0;
         ind = '0;
         if (tbl[i].pch >= 0) begin
            inv[tbl[i].pch] = 1'b1;
            ind[8*tbl[i].pch +: 8] = tbl[i].pb;
         end
         rdy = {tbl[i].rdy, 4'b0000};
         step($sformatf("vec%0d", i), tbl[i].req, tbl[i].we, tbl[i].byt, tbl[i].addr,
              tbl[i].wd, inv, ind, rdy, 1'b0);
         chk($sformatf("vec%0d tbl_ack", i), 32'(bus_ack), 32'(tbl[i].e_ack));
         chk($sformatf("vec%0d tbl_err", i), 32'(bus_err), 32'(tbl[i].e_err));
         if (tbl[i].e_ack) chk($sformatf("vec%0d tbl_rdata", i), 32'(bus_rdata), 32'(tbl[i].e_rd));
         chk($sformatf("vec%0d tbl_vld4", i), 32'(dev_out_valid[4]), 32'(tbl[i].e_vld));
         chk($sformatf("vec%0d tbl_od4", i), 32'(dev_out_data[39:32]), 32'(tbl[i].e_od));
      end

      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 8)       addr = 16'(BASE + 16'($urandom_range(0, 2*N-1)));
         else if (r == 8) addr = 16'h0040;
         else             addr = 16'($urandom);
         inv = N'($urandom) & N'($urandom);
         rdy = N'($urandom) & N'($urandom);
         ind = {8'($urandom), 32'($urandom)};
         step($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0), 1'($urandom),
              ($urandom_range(0, 3) != 0), addr, 16'($urandom), inv, ind, rdy, 1'b0);
      end

`ifdef XM23_DEV_IRQ_EN
      do_reset();
      step("irq_csr0", 1, 1, 1, 16'h0000, 16'h0021, '0, '0, '0, 0);
      step("irq_csr2", 1, 1, 1, 16'h0004, 16'h0061, '0, '0, '0, 0);
      step("irq_push", 0, 0, 0, 16'h0000, 16'h0000, 5'b00101, 40'h00_00_20_00_10, '0, 0);
      step("irq_wait", 0, 0, 0, 16'h0000, 16'h0000, '0, '0, '0, 0);
      chk("irq first req", 32'(irq_req), 32'd1);
      chk("irq first vect", 32'(irq_vect), 32'd2);
      chk("irq first pri", 32'(irq_pri), 32'd3);
      step("irq_ack1", 0, 0, 0, 16'h0000, 16'h0000, '0, '0, '0, 1);
      chk("irq second req", 32'(irq_req), 32'd1);
      chk("irq second vect", 32'(irq_vect), 32'd0);
      chk("irq second pri", 32'(irq_pri), 32'd1);
      step("irq_ack2", 0, 0, 0, 16'h0000, 16'h0000, '0, '0, '0, 1);
      chk("irq drop req", 32'(irq_req), 32'd0);
      step("irq_idle", 0, 0, 0, 16'h0000, 16'h0000, '0, '0, '0, 0);
      chk("irq no rearm", 32'(irq_req), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
